// File: rtl/cache_data_ram_fill_pkg.sv
// Shared definitions for the byte-lane cache data store and its fill engine.
package cache_data_ram_fill_pkg;

  localparam logic [1:0] FILL_IDLE   = 2'd0;
  localparam logic [1:0] FILL_ACTIVE = 2'd1;
  localparam logic [1:0] FILL_DONE   = 2'd2;

  function automatic int myclog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

  function automatic int lanes(input int data_bits);
    return data_bits / 8;
  endfunction

endpackage

// File: rtl/cache_data_ram_fill_if.sv
// Read, CPU write and line-fill signals of the cache data store.
interface cache_data_ram_fill_if #(
  parameter int addr_bits = 5,
  parameter int data_bits = 32
);
  logic                   read_en;
  logic [addr_bits-1:0]   read_addr;
  logic [data_bits-1:0]   read_data;
  logic                   read_valid;
  logic                   wr_en;
  logic [addr_bits-1:0]   write_addr;
  logic [data_bits-1:0]   write_data;
  logic [data_bits/8-1:0] bytesel;
  logic                   write_ready;
  logic                   fill_start;
  logic [addr_bits-1:0]   fill_addr;
  logic [data_bits-1:0]   fill_data;
  logic                   fill_valid;
  logic                   fill_ready;
  logic                   fill_busy;
  logic                   fill_done;

  modport master (
    output read_en, read_addr, wr_en, write_addr, write_data, bytesel,
           fill_start, fill_addr, fill_data, fill_valid,
    input  read_data, read_valid, write_ready, fill_ready, fill_busy, fill_done
  );

  modport slave (
    input  read_en, read_addr, wr_en, write_addr, write_data, bytesel,
           fill_start, fill_addr, fill_data, fill_valid,
    output read_data, read_valid, write_ready, fill_ready, fill_busy, fill_done
  );
endinterface

// File: rtl/block_ram.sv
// One byte lane of the data array: synchronous write, combinational read.
module block_ram #(
  parameter int nr_entries = 32,
  parameter int addr_bits  = 5
) (
  input  logic                 clk,
  input  logic                 i_we,
  input  logic [addr_bits-1:0] i_waddr,
  input  logic [7:0]           i_wdata,
  input  logic [addr_bits-1:0] i_raddr,
  output logic [7:0]           o_rdata
);
  logic [7:0] r_mem [nr_entries];

  // Byte write at the accepting edge; contents are intentionally never reset
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/cache_data_ram_fill_fill_ctrl.sv
// Line-fill sequencer: walks one cache line from its base address, one beat per accepted word.
module cache_fill_ctrl
  import cache_data_ram_fill_pkg::*;
#(
  parameter int addr_bits      = 5,
  parameter int words_per_line = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_fill_start,
  input  logic [addr_bits-1:0] i_fill_addr,
  input  logic                 i_fill_valid,
  output logic                 o_fill_we,
  output logic [addr_bits-1:0] o_fill_waddr,
  output logic                 o_fill_ready,
  output logic                 o_fill_busy,
  output logic                 o_fill_done
);
  localparam int off_bits = myclog2(words_per_line);
  localparam logic [addr_bits-1:0] OFF_MASK = addr_bits'(words_per_line - 1);
  localparam logic [off_bits-1:0]  LAST_BEAT = off_bits'(words_per_line - 1);

  logic [1:0]           r_state;
  logic [off_bits-1:0]  r_count;
  logic [addr_bits-1:0] r_base;
  logic                 w_active;
  logic                 w_beat;
  logic                 w_start;

  assign w_active = (r_state == FILL_ACTIVE);
  assign w_beat   = w_active && i_fill_valid;
  assign w_start  = !w_active && i_fill_start;

  // Fill state, beat counter and line base; a start is honoured in IDLE or DONE only
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= FILL_IDLE;
      r_count <= '0;
      r_base  <= '0;
    end else if (w_start) begin
      r_state <= FILL_ACTIVE;
      r_count <= '0;
      r_base  <= i_fill_addr & ~OFF_MASK;
    end else if (w_beat) begin
      r_count <= r_count + 1'b1;
      if (r_count == LAST_BEAT) r_state <= FILL_DONE;
    end else if (r_state == FILL_DONE) begin
      r_state <= FILL_IDLE;
    end
  end

  assign o_fill_we    = w_beat;
  assign o_fill_waddr = r_base | addr_bits'(r_count);
  assign o_fill_ready = w_active;
  assign o_fill_busy  = w_active;
  assign o_fill_done  = (r_state == FILL_DONE);
endmodule

// File: rtl/cache_data_ram_fill.sv
// Byte-lane cache data store with write-first forwarding, held read output and line fill.
module cache_data_ram_fill
  import cache_data_ram_fill_pkg::*;
#(
  parameter int nr_entries     = 32,
  parameter int data_bits      = 32,
  parameter int words_per_line = 8
) (
  input logic                 clk,
  input logic                 rst_n,
  cache_data_ram_fill_if.slave bus
);
  localparam int addr_bits = myclog2(nr_entries);
  localparam int NLANES    = lanes(data_bits);

  logic                 w_fill_we;
  logic [addr_bits-1:0] w_fill_waddr;
  logic                 w_fill_busy;
  logic                 w_cpu_we;
  logic [NLANES-1:0]    w_we_lanes;
  logic [addr_bits-1:0] w_waddr;
  logic [data_bits-1:0] w_wdata;
  logic [data_bits-1:0] w_ram_rdata;
  logic [data_bits-1:0] w_merged;
  logic                 w_addr_match;
  logic [data_bits-1:0] r_read_data;
  logic                 r_read_valid;

  cache_fill_ctrl #(
    .addr_bits      (addr_bits),
    .words_per_line (words_per_line)
  ) u_fill_ctrl (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_fill_start (bus.fill_start),
    .i_fill_addr  (bus.fill_addr),
    .i_fill_valid (bus.fill_valid),
    .o_fill_we    (w_fill_we),
    .o_fill_waddr (w_fill_waddr),
    .o_fill_ready (bus.fill_ready),
    .o_fill_busy  (w_fill_busy),
    .o_fill_done  (bus.fill_done)
  );

  assign bus.fill_busy   = w_fill_busy;
  assign bus.write_ready = !w_fill_busy;
  assign w_cpu_we        = bus.wr_en && !w_fill_busy;

  // Write port mux: a fill beat owns the port; CPU writes only when no fill is running
  always_comb begin
    w_we_lanes = '0;
    w_waddr    = bus.write_addr;
    w_wdata    = bus.write_data;
    if (w_fill_we) begin
      w_we_lanes = '1;
      w_waddr    = w_fill_waddr;
      w_wdata    = bus.fill_data;
    end else if (w_cpu_we) begin
      w_we_lanes = bus.bytesel;
    end
  end

  assign w_addr_match = (w_waddr == bus.read_addr);

  genvar g;
  generate
    for (g = 0; g < NLANES; g++) begin : g_lane
      block_ram #(
        .nr_entries (nr_entries),
        .addr_bits  (addr_bits)
      ) u_ram (
        .clk     (clk),
        .i_we    (w_we_lanes[g]),
        .i_waddr (w_waddr),
        .i_wdata (w_wdata[g*8 +: 8]),
        .i_raddr (bus.read_addr),
        .o_rdata (w_ram_rdata[g*8 +: 8])
      );
      assign w_merged[g*8 +: 8] = (w_addr_match && w_we_lanes[g]) ?
                                  w_wdata[g*8 +: 8] : w_ram_rdata[g*8 +: 8];
    end
  endgenerate

  // Read result register: captures the forwarded word on a read and holds it otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_read_data  <= '0;
      r_read_valid <= 1'b0;
    end else begin
      r_read_valid <= bus.read_en;
      if (bus.read_en) r_read_data <= w_merged;
    end
  end

  assign bus.read_data  = r_read_data;
  assign bus.read_valid = r_read_valid;
endmodule

// File: tb/tb_cache_data_ram_fill.sv
// Randomized scoreboard bench for cache_data_ram_fill with a word-level reference model.
module tb_cache_data_ram_fill;
  localparam int AW  = 5;
  localparam int DW  = 32;
  localparam int NE  = 32;
  localparam int WPL = 8;
  localparam int PH_IDLE = 0;
  localparam int PH_FILL = 1;
  localparam int PH_DONE = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cache_data_ram_fill_if #(.addr_bits(AW), .data_bits(DW)) bus();
  cache_data_ram_fill #(.nr_entries(NE), .data_bits(DW), .words_per_line(WPL)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  cache_data_ram_fill_if #(.addr_bits(6), .data_bits(64)) bus64();
  cache_data_ram_fill #(.nr_entries(64), .data_bits(64), .words_per_line(8)) dut64 (
    .clk(clk), .rst_n(rst_n), .bus(bus64)
  );

  typedef struct {
    logic        valid;
    logic [31:0] data;
    logic        ready;
    logic        busy;
    logic        done;
    logic        wready;
  } exp_t;

  exp_t        expQ[$];
  int          checkCount = 0;
  int          failCount = 0;
  logic [31:0] modelMem [NE];
  logic [31:0] lastRead = '0;
  int          fillPhase = PH_IDLE;
  int          fillBeats = 0;
  int          fillBase = 0;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  function automatic logic [31:0] mergeLanes(input logic [31:0] oldWord, input logic [31:0] newWord,
                                             input logic [3:0] mask);
    logic [31:0] result;
    result = oldWord;
    for (int m = 0; m < 4; m++) if (mask[m]) result[m*8 +: 8] = newWord[m*8 +: 8];
    return result;
  endfunction

  // One cycle of stimulus; the model applies the accepted write first, then the read sees it
  task automatic applyStimulus(input logic re, input logic [4:0] ra, input logic we, input logic [4:0] wa,
                               input logic [31:0] wd, input logic [3:0] bs, input logic fs,
                               input logic [4:0] fa, input logic [31:0] fd, input logic fv);
    exp_t        e;
    int          waddr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    @(negedge clk);
    bus.read_en = re;  bus.read_addr = ra;
    bus.wr_en = we;    bus.write_addr = wa; bus.write_data = wd; bus.bytesel = bs;
    bus.fill_start = fs; bus.fill_addr = fa; bus.fill_data = fd; bus.fill_valid = fv;
    waddr = 0; wdata = '0; wmask = '0;
    if (fillPhase == PH_FILL && fv) begin
      waddr = fillBase + fillBeats; wdata = fd; wmask = 4'hF;
    end else if (we && fillPhase != PH_FILL) begin
      waddr = int'(wa); wdata = wd; wmask = bs;
    end
    if (wmask != 4'h0) modelMem[waddr] = mergeLanes(modelMem[waddr], wdata, wmask);
    if (re) lastRead = modelMem[ra];
    if (fillPhase == PH_FILL) begin
      if (fv) begin
        fillBeats++;
        if (fillBeats == WPL) fillPhase = PH_DONE;
      end
    end else if (fs) begin
      fillPhase = PH_FILL; fillBeats = 0; fillBase = (int'(fa) / WPL) * WPL;
    end else if (fillPhase == PH_DONE) begin
      fillPhase = PH_IDLE;
    end
    e.valid = re; e.data = lastRead;
    e.ready = (fillPhase == PH_FILL); e.busy = (fillPhase == PH_FILL);
    e.done = (fillPhase == PH_DONE);  e.wready = (fillPhase != PH_FILL);
    expQ.push_back(e);
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, '0, 1'b0, '0, '0, '0, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic readAddr(input logic [4:0] ra);
    applyStimulus(1'b1, ra, 1'b0, '0, '0, '0, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic writeAddr(input logic [4:0] wa, input logic [31:0] wd, input logic [3:0] bs);
    applyStimulus(1'b0, '0, 1'b1, wa, wd, bs, 1'b0, '0, '0, 1'b0);
  endtask

  // Asynchronous reset in the middle of the low clock phase, checking outputs before any edge
  task automatic applyReset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.read_en = 1'b0; bus.wr_en = 1'b0; bus.fill_start = 1'b0; bus.fill_valid = 1'b0;
    #2;
    expQ.delete();
    fillPhase = PH_IDLE; fillBeats = 0; lastRead = '0;
    checkOutput("rst_read_data",   64'(bus.read_data),   64'd0);
    checkOutput("rst_read_valid",  64'(bus.read_valid),  64'd0);
    checkOutput("rst_fill_ready",  64'(bus.fill_ready),  64'd0);
    checkOutput("rst_fill_busy",   64'(bus.fill_busy),   64'd0);
    checkOutput("rst_fill_done",   64'(bus.fill_done),   64'd0);
    checkOutput("rst_write_ready", 64'(bus.write_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: compares every observable output one step after each edge against the queue
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("read_valid",  64'(bus.read_valid),  64'(e.valid));
        checkOutput("read_data",   64'(bus.read_data),   64'(e.data));
        checkOutput("fill_ready",  64'(bus.fill_ready),  64'(e.ready));
        checkOutput("fill_busy",   64'(bus.fill_busy),   64'(e.busy));
        checkOutput("fill_done",   64'(bus.fill_done),   64'(e.done));
        checkOutput("write_ready", 64'(bus.write_ready), 64'(e.wready));
      end
    end
  end

  initial begin
    int beats;
    bus.read_en = 1'b0; bus.read_addr = '0; bus.wr_en = 1'b0; bus.write_addr = '0;
    bus.write_data = '0; bus.bytesel = '0; bus.fill_start = 1'b0; bus.fill_addr = '0;
    bus.fill_data = '0; bus.fill_valid = 1'b0;
    bus64.read_en = 1'b0; bus64.read_addr = '0; bus64.wr_en = 1'b0; bus64.write_addr = '0;
    bus64.write_data = '0; bus64.bytesel = '0; bus64.fill_start = 1'b0; bus64.fill_addr = '0;
    bus64.fill_data = '0; bus64.fill_valid = 1'b0;
    #12;
    applyReset();

    for (int a = 0; a < NE; a++) writeAddr(5'(a), $urandom, 4'hF);

    writeAddr(5'd5, 32'hDEADBEEF, 4'hF);
    readAddr(5'd5);
    idleCycle();
    idleCycle();

    writeAddr(5'd3, 32'h11223344, 4'hF);
    applyStimulus(1'b1, 5'd3, 1'b1, 5'd3, 32'hAABBCCDD, 4'b0101, 1'b0, '0, '0, 1'b0);
    idleCycle();

    applyStimulus(1'b0, '0, 1'b0, '0, '0, '0, 1'b1, 5'h0B, '0, 1'b0);
    beats = 0;
    for (int k = 0; k < 15; k++) begin
      applyStimulus(1'b1, 5'(8 + (k % 8)), (k == 0), 5'd2, 32'hFFFFFFFF, 4'hF,
                    (beats == 3), 5'h18, 32'h100 + 32'(beats), (k % 2 == 0));
      if (k % 2 == 0) beats++;
    end
    writeAddr(5'd2, 32'hFFFFFFFF, 4'hF);
    idleCycle();
    for (int a = 8; a < 16; a++) readAddr(5'(a));
    readAddr(5'd2);
    readAddr(5'h18);
    idleCycle();

    for (int k = 0; k < 400; k++) begin
      applyStimulus($urandom_range(0, 1) == 1, 5'($urandom), $urandom_range(0, 1) == 1, 5'($urandom),
                    $urandom, 4'($urandom), $urandom_range(0, 19) == 0, 5'($urandom), $urandom,
                    $urandom_range(0, 2) != 0);
    end
    for (int k = 0; k < 12; k++) idleCycle();

    applyStimulus(1'b0, '0, 1'b0, '0, '0, '0, 1'b1, 5'($urandom), '0, 1'b0);
    for (int k = 0; k < 4; k++) applyStimulus(1'b0, '0, 1'b0, '0, '0, '0, 1'b0, '0, $urandom, 1'b1);
    applyReset();
    for (int k = 0; k < 12; k++) idleCycle();
    for (int a = 0; a < NE; a += 3) readAddr(5'(a));
    idleCycle();

    @(negedge clk);
    bus64.wr_en = 1'b1; bus64.write_addr = 6'd7; bus64.write_data = '0; bus64.bytesel = 8'hFF;
    @(negedge clk);
    bus64.write_data = 64'h0123456789ABCDEF; bus64.bytesel = 8'hF0;
    @(negedge clk);
    bus64.wr_en = 1'b0; bus64.read_en = 1'b1; bus64.read_addr = 6'd7;
    @(posedge clk);
    #1;
    checkOutput("w64_read_data",  bus64.read_data,         64'h0123456700000000);
    checkOutput("w64_read_valid", 64'(bus64.read_valid),   64'd1);
    @(negedge clk);
    bus64.read_en = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("w64_hold_data",  bus64.read_data,         64'h0123456700000000);
    checkOutput("w64_valid_low",  64'(bus64.read_valid),   64'd0);

    @(negedge clk);
    if (expQ.size() != 0) begin
      failCount++;
      $display("[TB] FAIL scoreboard_drain actual=%0d expected=0", expQ.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end
endmodule
